// File: rtl/lock_pkg.sv
// Shared types and constants for the door-lock ULA sequencer.
package lock_pkg;

    localparam int DIGIT_W = 8;

    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_SLT = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        COMPARE,
        RESULT,
        PROG_WRITE,
        LOCKOUT
    } state_e;

endpackage

// File: rtl/lock_lockout_timer.sv
// Lockout down-counter: loads LOCKOUT_CYCLES-1, done while the count is zero.
module lock_lockout_timer #(
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int W = $clog2(LOCKOUT_CYCLES + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(LOCKOUT_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/lock_ula_sequencer.sv
// Keypad collector, ULA-based code compare and password programming.
// Define LOCK_LOCKOUT_EN to enable the lockout state and timer.
module lock_ula_sequencer
    import lock_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 32'h01020304
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_data,
    output logic               key_ready,
    input  logic               cmd_prog,
    output logic [DIGIT_W-1:0] scra,
    output logic [DIGIT_W-1:0] scrb,
    output logic [2:0]         ula_control,
    input  logic [DIGIT_W-1:0] ula_result,
    input  logic               flagz,
    output logic               unlock,
    output logic               fail,
    output logic               prog_done,
    output logic               lockout,
    output logic               busy
);

    localparam int IDX_W = $clog2(CODE_LEN);
    localparam int FW    = $clog2(MAX_FAIL + 1);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(CODE_LEN - 1);
    localparam logic [FW-1:0]    FAIL_SAT = FW'(MAX_FAIL);

    // Digit 0 lives in the most significant byte.
    typedef logic [CODE_LEN-1:0][DIGIT_W-1:0] code_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    code_t            entered_q, entered_d;
    code_t            pwd_q, pwd_d;
    logic             mode_q, mode_d;
    logic             mismatch_q, mismatch_d;
    logic [FW-1:0]    fail_cnt_q, fail_cnt_d;
    logic [FW-1:0]    fail_nxt;
    logic [IDX_W-1:0] ridx;
    logic             unused_result;

    assign ridx          = LAST - idx_q;
    assign unused_result = ^ula_result;

`ifdef LOCK_LOCKOUT_EN
    logic tmr_load;
    logic tmr_done;

    lock_lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(tmr_load),
        .done(tmr_done)
    );

    assign lockout = (state_q == LOCKOUT);
`else
    logic [31:0] unused_cfg;

    assign unused_cfg = 32'(LOCKOUT_CYCLES);
    assign lockout    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        entered_d   = entered_q;
        pwd_d       = pwd_q;
        mode_d      = mode_q;
        mismatch_d  = mismatch_q;
        fail_cnt_d  = fail_cnt_q;
        fail_nxt    = fail_cnt_q;
        key_ready   = 1'b0;
        scra        = '0;
        scrb        = '0;
        ula_control = ULA_AND;
        unlock      = 1'b0;
        fail        = 1'b0;
        prog_done   = 1'b0;
        busy        = 1'b1;
`ifdef LOCK_LOCKOUT_EN
        tmr_load    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                key_ready = 1'b1;
                busy      = 1'b0;
                if (key_valid) begin
                    mode_d          = cmd_prog;
                    entered_d[LAST] = key_data;
                    idx_d           = IDX_W'(1);
                    state_d         = COLLECT;
                end
            end
            COLLECT: begin
                key_ready = 1'b1;
                busy      = 1'b0;
                if (key_valid) begin
                    entered_d[ridx] = key_data;
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = mode_q ? PROG_WRITE : COMPARE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            COMPARE: begin
                scra        = entered_q[ridx];
                scrb        = pwd_q[ridx];
                ula_control = ULA_SUB;
                mismatch_d  = mismatch_q | ~flagz;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = RESULT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            RESULT: begin
                if (mismatch_q) begin
                    fail = 1'b1;
                    if (fail_cnt_q != FAIL_SAT) begin
                        fail_nxt = fail_cnt_q + FW'(1);
                    end
                end else begin
                    unlock   = 1'b1;
                    fail_nxt = '0;
                end
                fail_cnt_d = fail_nxt;
                mismatch_d = 1'b0;
                idx_d      = '0;
                state_d    = IDLE;
`ifdef LOCK_LOCKOUT_EN
                if (fail_nxt == FAIL_SAT) begin
                    tmr_load = 1'b1;
                    state_d  = LOCKOUT;
                end
`endif
            end
            PROG_WRITE: begin
                pwd_d      = entered_q;
                prog_done  = 1'b1;
                fail_cnt_d = '0;
                state_d    = IDLE;
            end
            LOCKOUT: begin
`ifdef LOCK_LOCKOUT_EN
                if (tmr_done) begin
                    fail_cnt_d = '0;
                    state_d    = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            entered_q  <= '0;
            pwd_q      <= DEFAULT_CODE;
            mode_q     <= 1'b0;
            mismatch_q <= 1'b0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            entered_q  <= entered_d;
            pwd_q      <= pwd_d;
            mode_q     <= mode_d;
            mismatch_q <= mismatch_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

endmodule

// File: tb/tb_lock_ula_sequencer.sv
// Bench for lock_ula_sequencer: ULA model, expected-output timeline, random codes.
module tb_lock_ula_sequencer;

    localparam int L        = 4;
    localparam int MAX_FAIL = 3;
    localparam int LOCK_CYC = 1000;
`ifdef LOCK_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_data = '0;
    logic       cmd_prog = 1'b0;
    logic       key_ready;
    logic [7:0] scra, scrb, ula_result;
    logic [2:0] ula_control;
    logic       flagz, unlock, fail, prog_done, lockout, busy;

    always #5 clk = ~clk;

    lock_ula_sequencer dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_data(key_data),
        .key_ready(key_ready), .cmd_prog(cmd_prog), .scra(scra), .scrb(scrb),
        .ula_control(ula_control), .ula_result(ula_result), .flagz(flagz),
        .unlock(unlock), .fail(fail), .prog_done(prog_done),
        .lockout(lockout), .busy(busy)
    );

    // Combinational ULA attached to the operand/opcode interface
    always_comb begin
        case (ula_control)
            3'b000:  ula_result = scra & scrb;
            3'b001:  ula_result = scra | scrb;
            3'b010:  ula_result = scra + scrb;
            3'b110:  ula_result = scra - scrb;
            3'b111:  ula_result = (scra < scrb) ? 8'd1 : 8'd0;
            default: ula_result = '0;
        endcase
    end
    assign flagz = (ula_result == 8'd0);

    typedef struct packed {
        logic       kr;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       unl;
        logic       fl;
        logic       pd;
        logic       lk;
        logic       bsy;
    } ov_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfer_cyc = 0;
    int lat = -1;
    int n_unlock = 0, n_fail = 0, n_prog = 0, n_sub = 0, n_lock = 0, n_lock_kr = 0;

    ov_t        exp_q[$];
    logic [7:0] ent[$];
    logic [7:0] pwd[L];
    bit         mode_m;
    int         fcnt;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic ov_t idle_ov();
        ov_t o = '0;
        o.kr = 1'b1;
        return o;
    endfunction

    function automatic ov_t busy_ov();
        ov_t o = '0;
        o.bsy = 1'b1;
        return o;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        ent.delete();
        pwd[0] = 8'd1;
        pwd[1] = 8'd2;
        pwd[2] = 8'd3;
        pwd[3] = 8'd4;
        fcnt = 0;
    endfunction

    // Once a full code is in, lay out every later output cycle in exp_q.
    function automatic void schedule_code();
        ov_t o;
        bit  match = 1'b1;
        if (mode_m) begin
            o = busy_ov();
            o.pd = 1'b1;
            exp_q.push_back(o);
            for (int i = 0; i < L; i++) pwd[i] = ent[i];
            fcnt = 0;
        end else begin
            for (int i = 0; i < L; i++) begin
                o = busy_ov();
                o.op = 3'b110;
                o.a = ent[i];
                o.b = pwd[i];
                exp_q.push_back(o);
                if (ent[i] != pwd[i]) match = 1'b0;
            end
            o = busy_ov();
            if (match) begin
                o.unl = 1'b1;
                fcnt = 0;
            end else begin
                o.fl = 1'b1;
                if (fcnt < MAX_FAIL) fcnt++;
            end
            exp_q.push_back(o);
            if (LOCK_EN && fcnt == MAX_FAIL) begin
                o = busy_ov();
                o.lk = 1'b1;
                for (int k = 0; k < LOCK_CYC; k++) exp_q.push_back(o);
                fcnt = 0;
            end
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ov_t e;
        ov_t d;
        if (rst) begin
            model_reset();
        end else begin
            e = idle_ov();
            if (exp_q.size() != 0) e = exp_q.pop_front();
            d = {key_ready, scra, scrb, ula_control, unlock, fail, prog_done, lockout, busy};
            chk("outputs", 32'(d), 32'(e));
            if (e.kr && key_valid) begin
                if (ent.size() == 0) mode_m = cmd_prog;
                ent.push_back(key_data);
                if (ent.size() == L) begin
                    xfer_cyc = cyc;
                    schedule_code();
                    ent.delete();
                end
            end
            if (unlock || fail) lat = cyc - xfer_cyc;
            if (unlock) n_unlock++;
            if (fail) n_fail++;
            if (prog_done) n_prog++;
            if (ula_control == 3'b110) n_sub++;
            if (lockout) begin
                n_lock++;
                if (key_ready) n_lock_kr++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [7:0] dg, input bit prog, input bit tog);
        int n = 0;
        bit done = 1'b0;
        key_data = dg;
        cmd_prog = prog;
        while (!done) begin
            key_valid = tog ? ~key_valid : 1'b1;
            @(negedge clk);
            done = key_valid && key_ready;
            step();
            n++;
            if (!done && n > 3000) begin
                checks++;
                errors++;
                $display("FAIL handshake timeout: got no transfer expected transfer");
                done = 1'b1;
            end
        end
        if (!tog) key_valid = 1'b0;
        cmd_prog = 1'($urandom_range(0, 1));
    endtask

    task automatic send_code(input logic [31:0] code, input bit prog, input bit tog,
                             input bit gaps);
        for (int i = 0; i < L; i++) begin
            send_digit(code[31-8*i -: 8], prog, tog);
            if (gaps) repeat ($urandom_range(0, 2)) step();
        end
    endtask

    // Keypad noise while busy; quiet on the final busy cycle.
    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            key_valid = (exp_q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            key_data = 8'($urandom_range(0, 15));
            step();
            n++;
        end
        key_valid = 1'b0;
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle timeout: got busy expected idle");
        end
    endtask

    int s_u, s_f, s_p, s_s, s_l;

    task automatic snap();
        s_u = n_unlock;
        s_f = n_fail;
        s_p = n_prog;
        s_s = n_sub;
        s_l = n_lock;
    endtask

    initial begin
        logic [31:0] code;
        bit          prog;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset key_ready", 32'(key_ready), 32'd1);
        chk("reset outputs", 32'({unlock, fail, prog_done, lockout, busy}), 32'd0);
        chk("reset ula", 32'({ula_control, scra, scrb}), 32'd0);
        step();

        snap();
        send_code(32'h01020304, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("t1 sub cycles", 32'(n_sub - s_s), 32'd4);
        chk("t1 unlock", 32'(n_unlock - s_u), 32'd1);
        chk("t1 latency", 32'(lat), 32'd5);
        chk("t1 fail", 32'(n_fail - s_f), 32'd0);

        snap();
        send_code(32'h01020305, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("t2 fail once", 32'(n_fail - s_f), 32'd1);
        chk("t2 unlock", 32'(n_unlock - s_u), 32'd0);
`ifdef LOCK_LOCKOUT_EN
        snap();
        repeat (2) begin
            send_code(32'h01020305, 1'b0, 1'b0, 1'b1);
            wait_idle();
        end
        chk("t2 lock fails", 32'(n_fail - s_f), 32'd2);
        chk("t2 lockout cycles", 32'(n_lock - s_l), 32'd1000);
        chk("t2 key_ready in lockout", 32'(n_lock_kr), 32'd0);
        @(negedge clk);
        chk("t2 idle after lockout", 32'({key_ready, busy, lockout}), 32'b100);
        step();
`else
        snap();
        repeat (3) begin
            send_code(32'h01020305, 1'b0, 1'b0, 1'b1);
            wait_idle();
            @(negedge clk);
            chk("t2 key_ready after result", 32'(key_ready), 32'd1);
            step();
        end
        chk("t2 four fails", 32'(n_fail - s_f + 1), 32'd4);
        chk("t2 no lockout", 32'(n_lock), 32'd0);
`endif

        snap();
        send_code(32'h09080706, 1'b1, 1'b0, 1'b0);
        wait_idle();
        chk("t3 prog_done", 32'(n_prog - s_p), 32'd1);
        snap();
        send_code(32'h01020304, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("t3 old code fails", 32'(n_fail - s_f), 32'd1);
        snap();
        send_code(32'h09080706, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("t3 new code unlocks", 32'(n_unlock - s_u), 32'd1);

        snap();
        send_code(32'h01020A04, 1'b0, 1'b1, 1'b0);
        wait_idle();
        chk("t4 toggle sub cycles", 32'(n_sub - s_s), 32'd4);
        chk("t4 digit 0x0A fails", 32'(n_fail - s_f), 32'd1);

        snap();
        send_code(32'h09080706, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5 outputs after abort",
            32'({unlock, fail, prog_done, lockout, busy, ula_control, scra, scrb}), 32'd0);
        chk("t5 key_ready after abort", 32'(key_ready), 32'd1);
        step();
        repeat (10) step();
        chk("t5 aborted compare silent", 32'(n_unlock - s_u + n_fail - s_f), 32'd0);
        send_code(32'h01020304, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("t5 default password back", 32'(n_unlock - s_u), 32'd1);

        for (int t = 0; t < 40; t++) begin
            prog = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < L; i++) begin
                code[31-8*i -: 8] = pwd[i];
                if ($urandom_range(0, 1) == 0 || prog) code[31-8*i -: 8] = 8'($urandom_range(0, 11));
            end
            send_code(code, prog, ($urandom_range(0, 3) == 0), 1'b1);
            wait_idle();
            repeat ($urandom_range(0, 3)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
